// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter for the vector register file. Execution units share the
//   single write port. One writer is granted per cycle. The granted write is
//   registered and presented one cycle later as the set + mark-valid strobe.
//   A counter tracks destinations invalidated by decode and not yet written.
//   On a halt request the block drains that counter, then pulses the machine
//   halt flag.
//
//   Build option: REGFILE_WB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest requester index wins, no pointer
//     undefined -> round-robin starting after the last granted requester
//
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   req_valid/ready per-requester write handshake (ready is combinational)
//   req_id/req_data packed per-requester destination id / data, req 0 in LSBs
//   inv_en          decode invalidated a destination (outstanding +1)
//   halt_req        one-cycle halt request
//   rf_wr_*         registered register-file write + mark-valid strobe
//   rf_set_halt     one-cycle pulse on entry to HALTED
//   halted          block is in HALTED
//   outstanding     outstanding-write count
//   err             sticky protocol / counter error
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 32,
  parameter int REG_ID_W = 5,
  parameter int VEC_W    = 256,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*REG_ID_W-1:0] req_id,
  input  logic [NUM_REQ*VEC_W-1:0]    req_data,
  input  logic                        inv_en,
  input  logic                        halt_req,
  output logic                        rf_wr_en,
  output logic [REG_ID_W-1:0]         rf_wr_id,
  output logic [VEC_W-1:0]            rf_wr_data,
  output logic                        rf_set_halt,
  output logic                        halted,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REGS > (1 << REG_ID_W)) begin : g_bad_cfg
    $error("REG_ID_W too narrow for NUM_REGS");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_ID_W-1:0] wr_id_q, wr_id_d;
  logic [VEC_W-1:0]    wr_data_q, wr_data_d;
  logic                set_halt_q, set_halt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                found;
  logic                hs;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  // Lowest valid index wins.
  always_comb begin
    // NOTE: every variable of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Search starts at ptr_q and wraps, so the requester after the last grant
  // has the highest priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The pointer moves only on an accepted handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Grant is gated by reset so req_ready reads 0 while reset_n is low.
  always_comb begin
    grant = '0;
    if (found && reset_n && (state_q != ST_HALTED)) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);

  // Capture the granted write; it becomes the strobe next cycle.
  always_comb begin
    wr_en_d   = hs;
    wr_id_d   = '0;
    wr_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wr_id_d   = req_id[i*REG_ID_W +: REG_ID_W];
        wr_data_d = req_data[i*VEC_W +: VEC_W];
      end
    end
  end

  // Outstanding counter. The decrement follows the strobe, not the handshake.
  // An increment and a decrement in the same cycle cancel.
  always_comb begin
    logic inc;
    logic dec;
    inc   = inv_en && (state_q == ST_RUN);
    dec   = wr_en_q;
    cnt_d = cnt_q;
    err_d = err_q;
    // Decode must already be stalled once a halt is in progress.
    if (inv_en && (state_q != ST_RUN)) err_d = 1'b1;
    if (inc && !dec) begin
      if (cnt_q == '1) err_d = 1'b1;
      else             cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Next state. DRAIN exits only when nothing is counted, nothing is granted
  // and no strobe is pending. This keeps rf_set_halt apart from rf_wr_en.
  always_comb begin
    state_d    = state_q;
    set_halt_d = 1'b0;
    unique case (state_q)
      ST_RUN:   if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if ((cnt_q == '0) && !hs && !wr_en_q) begin
          state_d    = ST_HALTED;
          set_halt_d = 1'b1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the wide write-data register is reset too, because rf_wr_data must read 0 after reset; plain datapath flops normally are not.
      state_q    <= ST_RUN;
      wr_en_q    <= 1'b0;
      wr_id_q    <= '0;
      wr_data_q  <= '0;
      set_halt_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments, so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_id_q    <= wr_id_d;
      wr_data_q  <= wr_data_d;
      set_halt_q <= set_halt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign rf_wr_en    = wr_en_q;
  assign rf_wr_id    = wr_id_q;
  assign rf_wr_data  = wr_data_q;
  assign rf_set_halt = set_halt_q;
  assign halted      = (state_q == ST_HALTED);
  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge. Outputs are read after
// that, once the combinational ready has settled.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int REG_ID_W = 5;
  localparam int VEC_W    = 256;
  localparam int CNT_W    = 8;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*REG_ID_W-1:0] req_id;
  logic [NUM_REQ*VEC_W-1:0]    req_data;
  logic                        inv_en;
  logic                        halt_req;
  logic                        rf_wr_en;
  logic [REG_ID_W-1:0]         rf_wr_id;
  logic [VEC_W-1:0]            rf_wr_data;
  logic                        rf_set_halt;
  logic                        halted;
  logic [CNT_W-1:0]            outstanding;
  logic                        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [VEC_W-1:0] d0, d1, d2, pat_a5;

  regfile_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_REGS(32), .REG_ID_W(REG_ID_W),
    .VEC_W(VEC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data),
    .inv_en(inv_en), .halt_req(halt_req),
    .rf_wr_en(rf_wr_en), .rf_wr_id(rf_wr_id), .rf_wr_data(rf_wr_data),
    .rf_set_halt(rf_set_halt), .halted(halted),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VEC_W-1:0] got,
                       input logic [VEC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    inv_en    = 1'b0;
    halt_req  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic inv_n(input int n);
    inv_en = 1'b1;
    repeat (n) tick();
    inv_en = 1'b0;
  endtask

  initial begin
    d0     = {8{32'h0000_0a01}};
    d1     = {8{32'h0000_0b02}};
    d2     = {8{32'h0000_0c03}};
    pat_a5 = {32{8'hA5}};
    req_id   = {5'd3, 5'd2, 5'd1};
    req_data = {d2, d1, d0};
    idle_inputs();

    // Reset with every requester valid: everything reads 0.
    reset_n   = 1'b0;
    req_valid = 3'b111;
    tick();
    tick();
    check("rst_ready", VEC_W'(req_ready), 0);
    check("rst_wr_en", VEC_W'(rf_wr_en), 0);
    check("rst_wr_id", VEC_W'(rf_wr_id), 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_set_halt", VEC_W'(rf_set_halt), 0);
    check("rst_halted", VEC_W'(halted), 0);
    check("rst_outst", VEC_W'(outstanding), 0);
    check("rst_err", VEC_W'(err), 0);

    // After release requester 0 goes first and its strobe follows a cycle
    // later. No invalidation preceded it, so err is set and the count stays 0.
    reset_n = 1'b1;
    settle();
    check("first_grant", VEC_W'(req_ready), 3'b001);
    tick();
    req_valid = '0;
    check("first_strobe", VEC_W'(rf_wr_en), 1);
    check("first_id", VEC_W'(rf_wr_id), 1);
    check("first_data", rf_wr_data, d0);
    tick();
    check("wr_at0_err", VEC_W'(err), 1);
    check("wr_at0_cnt", VEC_W'(outstanding), 0);
    check("wr_at0_strobe_off", VEC_W'(rf_wr_en), 0);

    // Round-robin fairness over three always-valid requesters.
    do_reset();
    inv_n(6);
    check("fair_cnt6", VEC_W'(outstanding), 6);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("fair_ready%0d", k), VEC_W'(req_ready), VEC_W'(1 << (k % 3)));
      tick();
      check($sformatf("fair_id%0d", k), VEC_W'(rf_wr_id), VEC_W'(k % 3 + 1));
    end
    req_valid = '0;
    check("fair_wr_en", VEC_W'(rf_wr_en), 1);
    check("fair_data_last", rf_wr_data, d2);
    tick();
    check("fair_cnt0", VEC_W'(outstanding), 0);
    check("fair_err", VEC_W'(err), 0);

    // Requesters 0 and 2 held valid: alternate in round-robin, 0 always in
    // the fixed-priority build.
    do_reset();
    req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      settle();
`ifdef REGFILE_WB_FIXED_PRIO_EN
      check($sformatf("prio_ready%0d", k), VEC_W'(req_ready), 3'b001);
`else
      check($sformatf("rr02_ready%0d", k), VEC_W'(req_ready), (k % 2 == 0) ? 3'b001 : 3'b100);
`endif
      tick();
    end
    req_valid = '0;

    // An invalidation coincident with a strobe decrement leaves the count alone.
    do_reset();
    inv_n(4);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    inv_en    = 1'b1;
    check("simul_strobe", VEC_W'(rf_wr_en), 1);
    check("simul_cnt_pre", VEC_W'(outstanding), 4);
    tick();
    inv_en = 1'b0;
    check("simul_cnt", VEC_W'(outstanding), 4);
    check("simul_err", VEC_W'(err), 0);

    // Halt drain: two outstanding, two id-7 writes, then a single halt pulse.
    do_reset();
    req_id   = {5'd3, 5'd2, 5'd7};
    req_data = {d2, d1, pat_a5};
    inv_n(2);
    halt_req = 1'b1;
    tick();
    halt_req  = 1'b0;
    req_valid = 3'b001;
    check("drain_not_halted", VEC_W'(halted), 0);
    tick();
    check("drain_strobe1", VEC_W'(rf_wr_en), 1);
    check("drain_id1", VEC_W'(rf_wr_id), 7);
    check("drain_data1", rf_wr_data, pat_a5);
    tick();
    req_valid = '0;
    check("drain_strobe2", VEC_W'(rf_wr_en), 1);
    check("drain_sh_off2", VEC_W'(rf_set_halt), 0);
    tick();
    check("drain_idle", VEC_W'(rf_wr_en), 0);
    check("drain_sh_off3", VEC_W'(rf_set_halt), 0);
    check("drain_cnt0", VEC_W'(outstanding), 0);
    tick();
    check("halt_pulse", VEC_W'(rf_set_halt), 1);
    check("halt_flag", VEC_W'(halted), 1);
    check("halt_no_wr", VEC_W'(rf_wr_en), 0);
    tick();
    check("halt_pulse_end", VEC_W'(rf_set_halt), 0);
    check("halt_stays", VEC_W'(halted), 1);
    req_valid = 3'b111;
    settle();
    check("halt_no_ready", VEC_W'(req_ready), 0);
    check("halt_err", VEC_W'(err), 0);
    req_valid = '0;

    // Idle halt: DRAIN at N+1, HALTED at N+2; inv_en during DRAIN sets err.
    do_reset();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    inv_en   = 1'b1;
    check("qhalt_n1", VEC_W'(halted), 0);
    tick();
    inv_en = 1'b0;
    check("qhalt_n2", VEC_W'(halted), 1);
    check("qhalt_pulse", VEC_W'(rf_set_halt), 1);
    check("drain_inv_err", VEC_W'(err), 1);
    check("drain_inv_cnt", VEC_W'(outstanding), 0);

    // Reset mid-DRAIN drops the in-flight strobe.
    do_reset();
    inv_n(1);
    halt_req = 1'b1;
    tick();
    halt_req  = 1'b0;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    check("mid_strobe", VEC_W'(rf_wr_en), 1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_wr_en", VEC_W'(rf_wr_en), 0);
    check("mid_rst_cnt", VEC_W'(outstanding), 0);
    check("mid_rst_halted", VEC_W'(halted), 0);
    reset_n = 1'b1;

    // Counter saturation at the all-ones value.
    do_reset();
    inv_n(255);
    check("sat_cnt255", VEC_W'(outstanding), 255);
    check("sat_err0", VEC_W'(err), 0);
    inv_n(1);
    check("sat_hold", VEC_W'(outstanding), 255);
    check("sat_err1", VEC_W'(err), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
